// File: rtl/hack_pkg.sv
// Shared types and instruction-field positions for the Hack execution core.
package hack_pkg;

    localparam int WORD_W = 16;

    // Instruction bit positions.
    localparam int BIT_AINST = 15;  // 1 = A-instruction (load constant into A)
    localparam int BIT_ASEL  = 12;  // C-instruction ALU y source: 1 = A, 0 = M
    localparam int COMP_HI   = 11;  // zx nx zy ny f no occupy [11:6]
    localparam int COMP_LO   = 6;
    localparam int DEST_A    = 5;
    localparam int DEST_D    = 4;
    localparam int DEST_M    = 3;
    localparam int JUMP_NG   = 2;   // jump if result < 0
    localparam int JUMP_ZR   = 1;   // jump if result == 0
    localparam int JUMP_PS   = 0;   // jump if result > 0

    typedef logic [WORD_W-1:0] word_t;

    // Core sequencing: IDLE is program-load mode; each instruction is FETCH then EXEC.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

endpackage

// File: rtl/hack_alu.sv
// Combinational Hack ALU: optional zero/invert on each operand, add or AND, optional invert.
module hack_alu
    import hack_pkg::*;
(
    input  word_t      x,
    input  word_t      y,
    input  logic [5:0] comp,   // {zx, nx, zy, ny, f, no}
    output word_t      out,
    output logic       zr,
    output logic       ng
);

    word_t x_z, x_n, y_z, y_n, f_res;

    // Operand conditioning, function select and output inversion, in that order.
    always_comb begin
        x_z   = comp[5] ? '0 : x;
        x_n   = comp[4] ? ~x_z : x_z;
        y_z   = comp[3] ? '0 : y;
        y_n   = comp[2] ? ~y_z : y_z;
        f_res = comp[1] ? (x_n + y_n) : (x_n & y_n);
        out   = comp[0] ? ~f_res : f_res;
        zr    = (out == '0);
        ng    = out[WORD_W-1];
    end

endmodule

// File: rtl/hack_datapath.sv
// Multi-cycle Hack core: A/D/IR/PC registers, unified 128-word RAM, two-cycle FETCH/EXEC sequencing.
// A host loads the RAM through the prog_* port while the core sits in IDLE.
module hack_datapath
    import hack_pkg::*;
#(
    parameter int START_ADDR = 64,
    parameter int DEPTH      = 128
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic        prog_we,
    input  logic [6:0]  prog_addr,
    input  logic [15:0] prog_data,
    output logic [15:0] prog_rdata,
    output logic [15:0] pc_out,
    output logic [15:0] a_out,
    output logic [15:0] d_out,
    output logic [15:0] alu_out,
    output logic        zr,
    output logic        ng,
    output logic        instr_done
);

    localparam int ADDR_W = $clog2(DEPTH);

    state_t              state, next_state;
    word_t               a_reg, d_reg, ir, pc;
    word_t               mem [DEPTH];
    logic [ADDR_W-1:0]   ram_addr;
    word_t               ram_rdata, ram_wdata, alu_y, alu_res;
    logic                is_c_exec, ram_we, jump_taken, alu_zr, alu_ng;
    logic                unused_ir;

    // IR[14:13] carry no meaning in this instruction set.
    assign unused_ir = ^ir[14:13];

    // Single-port RAM address: host in IDLE, PC while fetching, A while executing.
    always_comb begin
        ram_addr = prog_addr;
        case (state)
            ST_FETCH: ram_addr = pc[ADDR_W-1:0];
            ST_EXEC:  ram_addr = a_reg[ADDR_W-1:0];
            default:  ram_addr = prog_addr;
        endcase
    end

    assign ram_rdata  = mem[ram_addr];
    assign prog_rdata = mem[prog_addr];

    // Write enable: host loads only when idle and not starting; M writes only from a C-instruction.
    // Reset gates both so an aborted instruction cannot leave a stray write.
    always_comb begin
        is_c_exec = (state == ST_EXEC) && !ir[BIT_AINST];
        ram_we    = !reset && (((state == ST_IDLE) && prog_we && !run) ||
                               (is_c_exec && ir[DEST_M]));
        ram_wdata = (state == ST_IDLE) ? prog_data : alu_res;
    end

    // RAM storage is never cleared by reset.
    always_ff @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
    end

    assign alu_y = ir[BIT_ASEL] ? a_reg : ram_rdata;

    hack_alu u_alu (
        .x    (d_reg),
        .y    (alu_y),
        .comp (ir[COMP_HI:COMP_LO]),
        .out  (alu_res),
        .zr   (alu_zr),
        .ng   (alu_ng)
    );

    // Jump condition from the current ALU result and the three jump bits.
    always_comb begin
        jump_taken = (ir[JUMP_NG] && alu_ng) ||
                     (ir[JUMP_ZR] && alu_zr) ||
                     (ir[JUMP_PS] && !alu_zr && !alu_ng);
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= next_state;
    end

    // Next state: run is sampled only in IDLE and EXEC, so an instruction always completes.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  next_state = run ? ST_FETCH : ST_IDLE;
            ST_FETCH: next_state = ST_EXEC;
            ST_EXEC:  next_state = run ? ST_FETCH : ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Register updates: IR on FETCH; A/D/PC on EXEC, all from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_reg      <= '0;
            d_reg      <= '0;
            ir         <= '0;
            pc         <= WORD_W'(START_ADDR);
            instr_done <= 1'b0;
        end else begin
            instr_done <= (state == ST_EXEC);
            if (state == ST_FETCH) ir <= ram_rdata;
            if (state == ST_EXEC) begin
                if (ir[BIT_AINST]) begin
                    a_reg <= {1'b0, ir[14:0]};
                    pc    <= pc + 16'd1;
                end else begin
                    if (ir[DEST_A]) a_reg <= alu_res;
                    if (ir[DEST_D]) d_reg <= alu_res;
                    pc <= jump_taken ? a_reg : pc + 16'd1;
                end
            end
        end
    end

    assign pc_out  = pc;
    assign a_out   = a_reg;
    assign d_out   = d_reg;
    assign alu_out = alu_res;
    assign zr      = alu_zr;
    assign ng      = alu_ng;

endmodule

// File: tb/tb_hack_datapath.sv
// Self-checking bench for hack_datapath: directed program scenarios plus a random program
// compared against an instruction-level model of the Hack machine.
module tb_hack_datapath;

    // ---------------- clock / reset / DUT ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        prog_we = 1'b0;
    logic [6:0]  prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic [15:0] prog_rdata, pc_out, a_out, d_out, alu_out;
    logic        zr, ng, instr_done;

    always #5 clock = ~clock;

    hack_datapath dut (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .prog_rdata (prog_rdata),
        .pc_out     (pc_out),
        .a_out      (a_out),
        .d_out      (d_out),
        .alu_out    (alu_out),
        .zr         (zr),
        .ng         (ng),
        .instr_done (instr_done)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference machine ----------------
    logic [15:0] ref_mem [128];
    logic [15:0] ref_a, ref_d, ref_pc;
    logic [47:0] exp_q [$];   // expected {pc, a, d} after each completed instruction

    function automatic logic [15:0] ref_alu(input logic [15:0] x, input logic [15:0] y,
                                            input logic [5:0] c);
        logic [15:0] xv, yv, r;
        xv = c[5] ? 16'h0000 : x;
        if (c[4]) xv = ~xv;
        yv = c[3] ? 16'h0000 : y;
        if (c[2]) yv = ~yv;
        r = c[1] ? 16'(xv + yv) : (xv & yv);
        if (c[0]) r = ~r;
        return r;
    endfunction

    // Execute one instruction on the model and record the expected architectural state.
    task automatic ref_step();
        logic [15:0] ins, old_a, yv, r;
        logic        lt, eq, gt, take;
        ins = ref_mem[ref_pc[6:0]];
        if (ins[15]) begin
            ref_a  = {1'b0, ins[14:0]};
            ref_pc = ref_pc + 16'd1;
        end else begin
            old_a = ref_a;
            yv    = ins[12] ? ref_a : ref_mem[ref_a[6:0]];
            r     = ref_alu(ref_d, yv, ins[11:6]);
            lt    = $signed(r) < 0;
            eq    = (r == 16'h0000);
            gt    = !lt && !eq;
            take  = (ins[2] && lt) || (ins[1] && eq) || (ins[0] && gt);
            if (ins[3]) ref_mem[old_a[6:0]] = r;
            if (ins[5]) ref_a = r;
            if (ins[4]) ref_d = r;
            ref_pc = take ? old_a : ref_pc + 16'd1;
        end
        exp_q.push_back({ref_pc, ref_a, ref_d});
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        reset = 1'b1; run = 1'b0; prog_we = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        ref_a = 16'h0000; ref_d = 16'h0000; ref_pc = 16'd64;
        exp_q.delete();
    endtask

    task automatic prog_write(input logic [6:0] addr, input logic [15:0] data);
        prog_addr = addr; prog_data = data; prog_we = 1'b1;
        @(negedge clock);
        prog_we = 1'b0;
        ref_mem[addr] = data;
    endtask

    // Run exactly n instructions from IDLE; with noise, hold a host write that must be ignored.
    // Each instr_done pulse is scored against the model's expected {pc, a, d}.
    task automatic run_instrs(input int n, input logic noise);
        logic [47:0] got, exp;
        for (int i = 0; i < n; i++) ref_step();
        run = 1'b1;
        if (noise) begin
            prog_addr = 7'd69; prog_data = 16'hBEEF; prog_we = 1'b1;
        end
        for (int e = 1; e <= 2 * n + 1; e++) begin
            @(posedge clock);
            @(negedge clock);
            if (e == 2 * n - 1) begin
                run = 1'b0; prog_we = 1'b0;
            end
            if (instr_done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL instr_done_extra got pulse at pc=%h expected no pulse", pc_out);
                end else begin
                    got = {pc_out, a_out, d_out};
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL sb_pc_a_d got %h expected %h", got, exp);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL instr_done_count got %0d missing pulses expected 0", exp_q.size());
        end
        exp_q.delete();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        #1;
        checks++; if (pc_out !== 16'd64) begin errors++; $display("FAIL reset_pc got %h expected %h", pc_out, 16'd64); end
        checks++; if (a_out !== 16'h0) begin errors++; $display("FAIL reset_a got %h expected 0000", a_out); end
        checks++; if (d_out !== 16'h0) begin errors++; $display("FAIL reset_d got %h expected 0000", d_out); end
        checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b expected 0", instr_done); end
    endtask

    task automatic test_load();
        logic [15:0] prog [6];
        prog = '{16'h8007, 16'h1C10, 16'h8003, 16'h1088, 16'h8050, 16'h0302};
        @(negedge clock);
        for (int i = 0; i < 6; i++) prog_write(7'(64 + i), prog[i]);
        for (int i = 0; i < 6; i++) begin
            prog_addr = 7'(64 + i);
            #1;
            checks++;
            if (prog_rdata !== prog[i]) begin
                errors++;
                $display("FAIL load_readback[%0d] got %h expected %h", 64 + i, prog_rdata, prog[i]);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_a_and_d();
        run_instrs(2, 1'b1);
        checks++; if (a_out !== 16'h0007) begin errors++; $display("FAIL a_inst got %h expected 0007", a_out); end
        checks++; if (d_out !== 16'h0007) begin errors++; $display("FAIL d_eq_a got %h expected 0007", d_out); end
        checks++; if (pc_out !== 16'd66) begin errors++; $display("FAIL pc_after2 got %h expected %h", pc_out, 16'd66); end
        prog_addr = 7'd69; #1;
        checks++; if (prog_rdata !== 16'h0302) begin errors++; $display("FAIL we_while_run got %h expected 0302", prog_rdata); end
    endtask

    task automatic test_m_write();
        run_instrs(2, 1'b0);
        prog_addr = 7'd3; #1;
        checks++; if (prog_rdata !== 16'h000A) begin errors++; $display("FAIL m_write got %h expected 000a", prog_rdata); end
        checks++; if (a_out !== 16'h0003) begin errors++; $display("FAIL m_write_a got %h expected 0003", a_out); end
        checks++; if (d_out !== 16'h0007) begin errors++; $display("FAIL m_write_d got %h expected 0007", d_out); end
    endtask

    task automatic test_jump_not_taken();
        run_instrs(2, 1'b0);
        checks++; if (alu_out !== 16'h0007) begin errors++; $display("FAIL jnt_alu got %h expected 0007", alu_out); end
        checks++; if (zr !== 1'b0) begin errors++; $display("FAIL jnt_zr got %b expected 0", zr); end
        checks++; if (pc_out !== 16'd70) begin errors++; $display("FAIL jnt_pc got %h expected %h", pc_out, 16'd70); end
    endtask

    task automatic test_jump_taken();
        prog_write(7'd70, 16'h0A90);   // D=0
        prog_write(7'd71, 16'h0302);   // D;JEQ with A=0x0050
        prog_write(7'd80, 16'h0E90);   // D=-1
        run_instrs(2, 1'b0);
        checks++; if (pc_out !== 16'h0050) begin errors++; $display("FAIL jt_pc got %h expected 0050", pc_out); end
        checks++; if (d_out !== 16'h0000) begin errors++; $display("FAIL jt_d0 got %h expected 0000", d_out); end
        checks++; if (zr !== 1'b1) begin errors++; $display("FAIL jt_zr got %b expected 1", zr); end
        run_instrs(1, 1'b0);
        checks++; if (d_out !== 16'hFFFF) begin errors++; $display("FAIL const_m1 got %h expected ffff", d_out); end
        checks++; if (ng !== 1'b1) begin errors++; $display("FAIL const_m1_ng got %b expected 1", ng); end
    endtask

    task automatic test_pc_wrap();
        prog_write(7'h51, 16'h0EA0);   // A=-1
        prog_write(7'h52, 16'h0A87);   // 0;JMP -> PC=0xFFFF
        prog_write(7'h7F, 16'h8005);   // fetched from 0xFFFF & 0x7F
        run_instrs(2, 1'b0);
        checks++; if (pc_out !== 16'hFFFF) begin errors++; $display("FAIL pc_ffff got %h expected ffff", pc_out); end
        run_instrs(1, 1'b0);
        checks++; if (pc_out !== 16'h0000) begin errors++; $display("FAIL pc_wrap got %h expected 0000", pc_out); end
        checks++; if (a_out !== 16'h0005) begin errors++; $display("FAIL pc_wrap_a got %h expected 0005", a_out); end
    endtask

    task automatic test_random_program();
        for (int i = 0; i < 128; i++) prog_write(7'(i), 16'($urandom_range(0, 16'hFFFF)));
        run_instrs(60, 1'b0);
        for (int i = 0; i < 128; i++) begin
            prog_addr = 7'(i);
            #1;
            checks++;
            if (prog_rdata !== ref_mem[i]) begin
                errors++;
                $display("FAIL rand_mem[%0d] got %h expected %h", i, prog_rdata, ref_mem[i]);
            end
        end
        @(negedge clock);
    endtask

    task automatic test_reset_mid_exec();
        do_reset();
        prog_write(7'd64, 16'h8003);   // A=3
        prog_write(7'd65, 16'h0E88);   // M=-1, aborted by reset
        prog_write(7'd3, 16'h1234);
        run = 1'b1;
        repeat (4) begin @(posedge clock); @(negedge clock); end
        checks++; if (a_out !== 16'h0003) begin errors++; $display("FAIL mid_exec_a got %h expected 0003", a_out); end
        reset = 1'b1; run = 1'b0;
        #1;
        checks++; if (pc_out !== 16'd64) begin errors++; $display("FAIL async_pc got %h expected %h", pc_out, 16'd64); end
        checks++; if (a_out !== 16'h0) begin errors++; $display("FAIL async_a got %h expected 0000", a_out); end
        checks++; if (d_out !== 16'h0) begin errors++; $display("FAIL async_d got %h expected 0000", d_out); end
        checks++; if (instr_done !== 1'b0) begin errors++; $display("FAIL async_done got %b expected 0", instr_done); end
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        prog_addr = 7'd3; #1;
        checks++; if (prog_rdata !== 16'h1234) begin errors++; $display("FAIL abort_write got %h expected 1234", prog_rdata); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_load();
        test_a_and_d();
        test_m_write();
        test_jump_not_taken();
        test_jump_taken();
        test_pc_wrap();
        test_random_program();
        test_reset_mid_exec();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
